// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared states, defaults and sample points for the UART receive path
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } rx_state_e;

    localparam int OVS_DEFAULT       = 16;
    localparam int DATA_BITS_DEFAULT = 8;

    localparam logic [3:0] SAMPLE_LO  = 4'd7;
    localparam logic [3:0] SAMPLE_MID = 4'd8;
    localparam logic [3:0] SAMPLE_HI  = 4'd9;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line input and received-byte output bundle
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT
);
    logic                 sel;
    logic                 rxd;
    logic [DATA_BITS-1:0] dout;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output sel,
        output rxd,
        input  dout,
        input  valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  sel,
        input  rxd,
        output dout,
        output valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_tick_gen.sv
// rtl/uart_tick_gen.sv - clearable divide-by-DIV counter producing a one-clk tick on wrap
module uart_tick_gen #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        wrap;

    always_comb begin
        wrap  = (cnt_q == 16'(DIV - 1));
        cnt_d = cnt_q + 16'd1;
        if (clr || wrap) begin
            cnt_d = '0;
        end
    end

    assign tick = wrap && !clr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampled UART receiver, 8N1 with majority vote and framing check
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIV       = 27,
    parameter int OVS       = OVS_DEFAULT,
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave rx
);
    localparam int SW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic                 rx_meta_q, rx_meta_d;
    logic                 rxs_q, rxs_d;
    logic                 rxs_prev_q, rxs_prev_d;
    logic [1:0]           fill_q, fill_d;
    logic [SW-1:0]        s_q, s_d;
    logic [BW-1:0]        b_q, b_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    logic tick;
    logic start_edge;
    logic m;
    logic at_hi;
    logic at_last;

    uart_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == IDLE),
        .tick  (tick)
    );

    // The sync chain holds its reset value of 1 for two clocks; that is not
    // real line history, so a line already low out of reset is not a start edge.
    always_comb begin
        rx_meta_d  = rx.rxd;
        rxs_d      = rx_meta_q;
        fill_d     = {fill_q[0], 1'b1};
        rxs_prev_d = rxs_q & fill_q[1];
        start_edge = rxs_prev_q & ~rxs_q;
    end

    always_comb begin
        m       = majority3(smp_q[1], smp_q[0], rxs_q);
        at_hi   = tick && (s_q == SW'(SAMPLE_HI));
        at_last = tick && (s_q == S_LAST);

        state_d = state_q;
        s_d     = tick ? s_q + 1'b1 : s_q;
        b_d     = b_q;
        smp_d   = smp_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        if (tick && s_q == SW'(SAMPLE_LO)) begin
            smp_d[1] = rxs_q;
        end
        if (tick && s_q == SW'(SAMPLE_MID)) begin
            smp_d[0] = rxs_q;
        end

        case (state_q)
            IDLE: begin
                if (rx.sel && start_edge) begin
                    state_d = START;
                end
            end
            START: begin
                if (at_hi && m) begin
                    state_d = IDLE;
                end else if (at_last) begin
                    state_d = DATA;
                    b_d     = '0;
                end
            end
            DATA: begin
                if (at_hi) begin
                    shreg_d = {m, shreg_q[DATA_BITS-1:1]};
                end
                if (at_last) begin
                    if (b_q == B_LAST) begin
                        state_d = STOP;
                    end else begin
                        b_d = b_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (at_hi) begin
                    if (m) begin
                        dout_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Standby wins over any decision made this cycle, including a stop-bit result.
        if (!rx.sel) begin
            state_d = IDLE;
            dout_d  = dout_q;
            valid_d = 1'b0;
            ferr_d  = 1'b0;
        end

        if (state_d != state_q) begin
            s_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b0;
            fill_q     <= '0;
            state_q    <= IDLE;
            s_q        <= '0;
            b_q        <= '0;
            smp_q      <= '0;
            shreg_q    <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rxs_q      <= rxs_d;
            rxs_prev_q <= rxs_prev_d;
            fill_q     <= fill_d;
            state_q    <= state_d;
            s_q        <= s_d;
            b_q        <= b_d;
            smp_q      <= smp_d;
            shreg_q    <= shreg_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rx.dout      = dout_q;
    assign rx.valid     = valid_q;
    assign rx.frame_err = ferr_q;
    assign rx.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with DIV=4 (64 clk per bit)
module tb_uart_rx;
    localparam int DIV = 4;
    localparam int BIT = DIV * 16;

    logic clk;
    logic rst_n;

    uart_rx_if #(.DATA_BITS(8)) rx_bus ();

    uart_rx #(.DIV(DIV), .OVS(16), .DATA_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int valid_cnt      = 0;
    int ferr_cnt       = 0;
    int overlap_cnt    = 0;
    int last_valid_cyc = 0;
    int ev_q[$];
    int start_cyc      = 0;

    always @(negedge clk) begin
        if (rx_bus.valid === 1'b1 && rx_bus.frame_err === 1'b1) overlap_cnt++;
        if (rx_bus.valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            ev_q.push_back(int'(rx_bus.dout));
        end
        if (rx_bus.frame_err === 1'b1) begin
            ferr_cnt++;
            ev_q.push_back(256);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic clks(input int n);
        if (n > 0) begin
            for (int k = 0; k < n; k++) @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic b, input int n);
        rx_bus.rxd = b;
        clks(n);
    endtask

    function automatic logic [9:0] framing(input logic [7:0] d, input logic stop);
        return {stop, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [9:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) drive(f[i], BIT);
    endtask

    // A bad stop bit is held low for two bit times before the line returns high.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        start_cyc = cyc;
        send_bits(framing(d, 1'b1), 0, 8);
        if (stop_ok) drive(1'b1, BIT);
        else         drive(1'b0, 2 * BIT);
        rx_bus.rxd = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         gap;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vec[6];

    initial begin
        int v0, f0, lat0;
        logic [9:0] f;
        int exp_q[$];
        logic [7:0] model_dout;

        vec[0] = '{8'hA5, 1'b1, 2, 1, 0, 8'hA5};
        vec[1] = '{8'h3C, 1'b0, 1, 0, 1, 8'hA5};
        vec[2] = '{8'h5A, 1'b1, 1, 1, 0, 8'h5A};
        vec[3] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
        vec[4] = '{8'hFF, 1'b1, 0, 1, 0, 8'hFF};
        vec[5] = '{8'h81, 1'b1, 2, 1, 0, 8'h81};

        rst_n      = 1'b0;
        rx_bus.sel = 1'b0;
        rx_bus.rxd = 1'b1;
        clks(5);
        check("reset_dout", rx_bus.dout, 8'h00);
        check("reset_valid", rx_bus.valid, 1'b0);
        check("reset_frame_err", rx_bus.frame_err, 1'b0);
        check("reset_busy", rx_bus.busy, 1'b0);
        rst_n      = 1'b1;
        rx_bus.sel = 1'b1;
        drive(1'b1, 2 * BIT);

        // Glitch: 16 clk low is far shorter than the centre-sample window.
        v0 = valid_cnt; f0 = ferr_cnt;
        drive(1'b0, 8);
        check("glitch_busy_high", rx_bus.busy, 1'b1);
        drive(1'b0, 8);
        drive(1'b1, 44);
        check("glitch_idle_by_60", rx_bus.busy, 1'b0);
        check("glitch_no_valid", valid_cnt - v0, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);
        check("glitch_dout", rx_bus.dout, 8'h00);
        drive(1'b1, BIT);

        lat0 = 0;
        for (int i = 0; i < 6; i++) begin
            v0 = valid_cnt; f0 = ferr_cnt;
            send_frame(vec[i].data, vec[i].stop_ok);
            if (i == 0) lat0 = last_valid_cyc - start_cyc;
            drive(1'b1, vec[i].gap * BIT);
            check($sformatf("vec%0d_valid", i), valid_cnt - v0, vec[i].exp_valid);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vec[i].exp_ferr);
            check($sformatf("vec%0d_dout", i), rx_bus.dout, vec[i].exp_dout);
        end
        check("latency_window", (lat0 >= 2 + 9 * BIT) && (lat0 <= 2 + 10 * BIT), 1'b1);

        // Reset pulse during data bit 4 of 0xC3.
        v0 = valid_cnt; f0 = ferr_cnt;
        f = framing(8'hC3, 1'b1);
        send_bits(f, 0, 4);
        drive(f[5], 10);
        rst_n = 1'b0;
        clks(1);
        check("rstmid_dout", rx_bus.dout, 8'h00);
        check("rstmid_valid", rx_bus.valid, 1'b0);
        check("rstmid_frame_err", rx_bus.frame_err, 1'b0);
        check("rstmid_busy", rx_bus.busy, 1'b0);
        rst_n = 1'b1;
        drive(f[5], BIT - 11);
        send_bits(f, 6, 9);
        drive(1'b1, 2 * BIT);
        check("rstmid_no_valid", valid_cnt - v0, 0);
        check("rstmid_no_ferr", ferr_cnt - f0, 0);
        v0 = valid_cnt;
        send_frame(8'h7E, 1'b1);
        drive(1'b1, BIT);
        check("after_rst_valid", valid_cnt - v0, 1);
        check("after_rst_dout", rx_bus.dout, 8'h7E);

        // sel gating: standby frame, then enable in the last data bit.
        v0 = valid_cnt; f0 = ferr_cnt;
        rx_bus.sel = 1'b0;
        f = framing(8'h55, 1'b1);
        send_bits(f, 0, 4);
        check("sel0_busy", rx_bus.busy, 1'b0);
        send_bits(f, 5, 9);
        drive(1'b1, BIT);
        send_bits(f, 0, 7);
        drive(f[8], BIT / 2);
        rx_bus.sel = 1'b1;
        drive(f[8], BIT / 2);
        send_bits(f, 9, 9);
        drive(1'b1, BIT);
        check("sel_gate_no_valid", valid_cnt - v0, 0);
        check("sel_gate_no_ferr", ferr_cnt - f0, 0);
        check("sel_gate_dout", rx_bus.dout, 8'h7E);
        send_frame(8'h55, 1'b1);
        drive(1'b1, BIT);
        check("sel_full_valid", valid_cnt - v0, 1);
        check("sel_full_dout", rx_bus.dout, 8'h55);

        // sel dropped mid-frame aborts with no pulses.
        v0 = valid_cnt; f0 = ferr_cnt;
        f = framing(8'h99, 1'b1);
        send_bits(f, 0, 3);
        drive(f[4], 16);
        check("abort_busy_before", rx_bus.busy, 1'b1);
        rx_bus.sel = 1'b0;
        drive(f[4], 2);
        check("abort_busy_after", rx_bus.busy, 1'b0);
        drive(f[4], BIT - 18);
        send_bits(f, 5, 9);
        drive(1'b1, BIT);
        rx_bus.sel = 1'b1;
        drive(1'b1, BIT);
        check("abort_no_valid", valid_cnt - v0, 0);
        check("abort_no_ferr", ferr_cnt - f0, 0);
        check("abort_dout", rx_bus.dout, 8'h55);

        // Random frames against a frame-level model of received events.
        ev_q.delete();
        model_dout = 8'h55;
        for (int i = 0; i < 14; i++) begin
            logic [7:0] d;
            logic ok;
            int gap;
            d   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 4) != 0);
            gap = ok ? $urandom_range(0, 2) : $urandom_range(1, 2);
            send_frame(d, ok);
            drive(1'b1, gap * BIT);
            if (ok) begin
                exp_q.push_back(int'(d));
                model_dout = d;
            end else begin
                exp_q.push_back(256);
            end
        end
        drive(1'b1, 2 * BIT);
        check("rand_event_count", ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            check($sformatf("rand_event%0d", i), ev_q[i], exp_q[i]);
        end
        check("rand_final_dout", rx_bus.dout, model_dout);
        check("rand_final_busy", rx_bus.busy, 1'b0);
        check("no_valid_ferr_overlap", overlap_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
